stream_sample_sink: RTL and testbench
=====================================

Name: stream_sample_sink

Overview:
Avalon-ST sink that receives mixed 24-bit audio samples from the mSGDMA stream. It buffers them in a ring FIFO and replays them at a fixed sample rate, one sample per tick, to the DAC path. It is the consumer end of the synthesizer's 96 kHz Avalon-ST sample stream: it drains a DMA channel instead of producing one. It has a single clock domain, with an internal rate divider in place of a separate slow clock.

Parameters:
DEPTH, 128, FIFO depth in samples; power of two, at least 4.
CLK_HZ, 50_000_000, system clock frequency.
SAMPLE_HZ, 96_000, output sample rate.
(Derived) DIV = CLK_HZ/SAMPLE_HZ, truncated; at least 2. For the defaults DIV = 520.

Ports:
clk  in  1  system clock; all logic on the rising edge.
n_rst  in  1  asynchronous, active-low reset.
i_enable  in  1  playback enable; level-sensitive.
asi_ss0_data  in  32  stream data; bits [23:0] are the signed sample, bits [31:24] are ignored.
asi_ss0_valid  in  1  source has data.
asi_ss0_ready  out  1  sink can accept data.
o_sample  out  24  signed sample to the DAC, registered.
o_sample_strobe  out  1  one-cycle pulse when o_sample updates.
o_underrun  out  1  one-cycle pulse on an underrun.
o_level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (n_rst low, asynchronous):
  - FIFO pointers, level, divider counter and state all clear; state becomes IDLE.
  - o_sample = 0, o_sample_strobe = 0, o_underrun = 0, o_level = 0.
  - asi_ss0_ready = 0 while in reset.
  - Asserting reset mid-transfer discards the whole FIFO. No partial state survives.
- Handshake:
  - asi_ss0_ready = (level < DEPTH), decoded combinationally from the registered level.
  - A beat transfers in any cycle where valid && ready.
  - Data is written at the write pointer, the pointer wraps from DEPTH-1 to 0, and level increments.
  - The sink accepts data in every state, including IDLE. Zero readyLatency.
- Rate divider:
  - The counter runs 0..DIV-1 only outside IDLE and is held at 0 in IDLE.
  - tick = (counter == DIV-1).
  - The first tick after leaving IDLE occurs DIV cycles later.
- State machine:
  - IDLE: entered from reset or when i_enable = 0, from any state. o_sample is held at 0 and no strobes are issued. Goes to PREFILL when i_enable = 1.
  - PREFILL: ticks are ignored (no pop, no strobe). Goes to RUN once level >= DEPTH/2.
  - RUN, on a tick with level > 0: pop at the read pointer (wrapping), load o_sample the next cycle, and pulse o_sample_strobe in that same cycle.
  - RUN, on a tick with level == 0: underrun. Pulse o_underrun, set o_sample = 0, pulse o_sample_strobe, and go to PREFILL.
- Latency:
  - A tick seen in cycle N gives o_sample/o_sample_strobe valid in cycle N+1.
  - A sample accepted in cycle N is visible in level from N+1 and is poppable from N+1.
- Simultaneous push and pop in one cycle: both happen and level is unchanged.
  - At full, a pop frees space only from the next cycle; ready is not forwarded.
  - At empty, a same-cycle push does not satisfy the pop, so an underrun is declared.
- Full: ready stays low and the source stalls. No beats are dropped.
- o_level is a registered copy of level.

Optional Feature:
Macro STREAM_SINK_HOLD_LAST_EN.
- Defined: on an underrun, o_sample keeps its last popped value instead of 0. o_underrun and o_sample_strobe still pulse, and the transition to PREFILL is unchanged. Leaving IDLE still forces 0.
- Undefined: on an underrun, o_sample is forced to 0, as described in Behaviour.

Test Plan:
All scenarios use DEPTH=8, CLK_HZ=960, SAMPLE_HZ=96, giving DIV=10.
1. Reset release with i_enable=0 and valid=0 -> ready=1, level=0, o_sample=0, no strobes for 100 cycles.
2. Push 0x000001..0x000004 back-to-back with i_enable=1 -> level reaches 4, the block enters RUN, and strobes occur every 10 cycles with o_sample = 1, 2, 3, 4 in order.
3. Drive 12 beats with valid held high and no enable -> exactly 8 accepted, ready=0 from cycle 9, level=8, and beats 9..12 are held by the source until space is freed.
4. Continue from scenario 2 with no further input -> the 5th tick gives o_underrun=1 and o_sample=0, then the block returns to PREFILL with no strobes until level >= 4. With STREAM_SINK_HOLD_LAST_EN defined, o_sample stays 0x000004 instead.
5. Push 0xFFFFFF, that is bits [31:24]=0xAB with data 0xABFFFFFF -> the corresponding strobe gives o_sample = 0xFFFFFF (-1); the upper byte is ignored.
6. Assert n_rst mid-RUN with level=5 and a push active in the same cycle -> outputs go to 0 immediately (asynchronously), level=0 after release, and no stale samples appear on later strobes.

Source files
------------

// File: rtl/stream_sample_sink.sv
// Avalon-ST sink: buffers 24-bit samples in a ring FIFO, replays one per tick.
// Optional: define STREAM_SINK_HOLD_LAST_EN to hold the last sample on underrun.
module stream_sample_sink #(
    parameter int DEPTH     = 128,
    parameter int CLK_HZ    = 50_000_000,
    parameter int SAMPLE_HZ = 96_000
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     i_enable,
    input  logic [31:0]              asi_ss0_data,
    input  logic                     asi_ss0_valid,
    output logic                     asi_ss0_ready,
    output logic [23:0]              o_sample,
    output logic                     o_sample_strobe,
    output logic                     o_underrun,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW  = $clog2(DEPTH);
    localparam int DIV = CLK_HZ / SAMPLE_HZ;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {
        IDLE,
        PREFILL,
        RUN
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level;
    logic [CW-1:0] div_cnt;
    logic [23:0]   mem [DEPTH];
    logic          push;
    logic          pop;
    logic          tick;
    logic          run_tick;
    logic          underrun;
    logic          unused_data;

    // Upper stream byte carries no audio.
    assign unused_data = ^asi_ss0_data[31:24];

    // Ready comes from the registered level only; held low during reset.
    assign asi_ss0_ready = n_rst && (level < (AW+1)'(DEPTH));
    assign push          = asi_ss0_valid && asi_ss0_ready;
    assign tick          = (state != IDLE) && (div_cnt == CW'(DIV - 1));
    assign run_tick      = tick && (state == RUN) && i_enable;
    assign pop           = run_tick && (level != '0);
    assign underrun      = run_tick && (level == '0);
    assign o_level       = level;

    // Next-state decode; disable wins from any state.
    always_comb begin
        state_n = state;
        if (!i_enable) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE:    state_n = PREFILL;
                PREFILL: if (level >= (AW+1)'(DEPTH / 2)) state_n = RUN;
                RUN:     if (underrun) state_n = PREFILL;
                default: state_n = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_n;
    end

    // Rate divider; parked at zero while idle.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)              div_cnt <= '0;
        else if (state == IDLE)  div_cnt <= '0;
        else if (tick)           div_cnt <= '0;
        else                     div_cnt <= div_cnt + 1'b1;
    end

    // Sample storage; stale words are unreachable once pointers reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= asi_ss0_data[23:0];
    end

    // Ring pointers and occupancy.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      level <= level + 1'b1;
            else if (pop && !push) level <= level - 1'b1;
        end
    end

    // Output sample register and one-cycle pulses.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            o_sample        <= '0;
            o_sample_strobe <= 1'b0;
            o_underrun      <= 1'b0;
        end else begin
            o_sample_strobe <= pop || underrun;
            o_underrun      <= underrun;
            if (state == IDLE || state_n == IDLE) begin
                o_sample <= '0;
            end else if (pop) begin
                o_sample <= mem[rd_ptr];
            end else if (underrun) begin
`ifdef STREAM_SINK_HOLD_LAST_EN
                o_sample <= o_sample;
`else
                o_sample <= '0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_stream_sample_sink.sv
// Bench for stream_sample_sink: directed scenarios plus random traffic
// checked every cycle against a queue-based reference model.
module tb_stream_sample_sink;

    localparam int DEPTH     = 8;
    localparam int CLK_HZ    = 960;
    localparam int SAMPLE_HZ = 96;
    localparam int DIV       = CLK_HZ / SAMPLE_HZ;
`ifdef STREAM_SINK_HOLD_LAST_EN
    localparam logic [23:0] UND_AFTER4 = 24'h000004;
`else
    localparam logic [23:0] UND_AFTER4 = 24'h000000;
`endif

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        i_enable = 1'b0;
    logic [31:0] asi_ss0_data = '0;
    logic        asi_ss0_valid = 1'b0;
    logic        asi_ss0_ready;
    logic [23:0] o_sample;
    logic        o_sample_strobe;
    logic        o_underrun;
    logic [3:0]  o_level;

    int checks = 0;
    int failures = 0;

    // Reference model state: 0 idle, 1 prefill, 2 run.
    logic [23:0] q[$];
    int          mode;
    int          k;
    logic [23:0] m_sample;
    logic        m_strobe;
    logic        m_under;
    logic        last_acc;

    logic [23:0] seen[$];
    int          ucount;
    logic [31:0] b [12];
    int          idx;

    stream_sample_sink #(
        .DEPTH(DEPTH),
        .CLK_HZ(CLK_HZ),
        .SAMPLE_HZ(SAMPLE_HZ)
    ) dut (
        .clk(clk),
        .n_rst(n_rst),
        .i_enable(i_enable),
        .asi_ss0_data(asi_ss0_data),
        .asi_ss0_valid(asi_ss0_valid),
        .asi_ss0_ready(asi_ss0_ready),
        .o_sample(o_sample),
        .o_sample_strobe(o_sample_strobe),
        .o_underrun(o_underrun),
        .o_level(o_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [23:0] obs,
                         input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        mode = 0;
        k = 0;
        m_sample = '0;
        m_strobe = 1'b0;
        m_under = 1'b0;
        last_acc = 1'b0;
    endtask

    // One clock edge of the behavioural rules, using pre-edge inputs.
    task automatic model_edge();
        bit acc, tck, rt, pp, und;
        int nm;
        logic [23:0] v;
        acc = asi_ss0_valid && (q.size() < DEPTH);
        tck = (mode != 0) && ((k % DIV) == DIV - 1);
        rt  = tck && (mode == 2) && i_enable;
        pp  = rt && (q.size() > 0);
        und = rt && (q.size() == 0);
        if (!i_enable)                             nm = 0;
        else if (mode == 0)                        nm = 1;
        else if (mode == 1 && q.size() >= DEPTH/2) nm = 2;
        else if (mode == 2 && und)                 nm = 1;
        else                                       nm = mode;
        v = '0;
        if (pp)  v = q.pop_front();
        if (acc) q.push_back(asi_ss0_data[23:0]);
        if (nm == 0 || mode == 0) m_sample = '0;
        else if (pp)              m_sample = v;
        else if (und) begin
`ifdef STREAM_SINK_HOLD_LAST_EN
            m_sample = m_sample;
`else
            m_sample = '0;
`endif
        end
        m_strobe = pp || und;
        m_under  = und;
        k        = (mode == 0) ? 0 : k + 1;
        mode     = nm;
        last_acc = acc;
    endtask

    task automatic cycle();
        @(posedge clk);
        if (n_rst) model_edge();
        else       last_acc = 1'b0;
        #1;
        check("ready", 24'(asi_ss0_ready),
              24'(n_rst && (q.size() < DEPTH)));
        check("level", 24'(o_level), 24'(q.size()));
        check("sample", o_sample, m_sample);
        check("strobe", 24'(o_sample_strobe), 24'(m_strobe));
        check("underrun", 24'(o_underrun), 24'(m_under));
        if (o_sample_strobe) seen.push_back(o_sample);
        if (o_underrun) ucount++;
    endtask

    initial begin
        model_reset();
        ucount = 0;
        repeat (3) cycle();
        #2 n_rst = 1'b1;

        // Idle after reset: ready, empty, silent.
        repeat (100) cycle();
        check("s1_strobes", 24'(seen.size()), 24'd0);
        check("s1_level", 24'(o_level), 24'd0);

        // Four pushes with playback enabled, then drain into an underrun.
        i_enable = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            asi_ss0_valid = 1'b1;
            asi_ss0_data  = 32'(i);
            cycle();
        end
        asi_ss0_valid = 1'b0;
        repeat (52) cycle();
        check("s2_count", 24'(seen.size()), 24'd5);
        for (int i = 0; i < 4; i++) check("s2_order", seen[i], 24'(i + 1));
        check("s4_und_sample", seen[4], UND_AFTER4);
        check("s4_und_count", 24'(ucount), 24'd1);
        repeat (30) cycle();
        check("s4_prefill_quiet", 24'(seen.size()), 24'd5);

        // Fill while disabled: exactly DEPTH beats land, then stall.
        i_enable = 1'b0;
        cycle();
        seen.delete();
        ucount = 0;
        for (int i = 0; i < 12; i++) b[i] = $urandom;
        b[4] = 32'hABFFFFFF;
        idx = 0;
        for (int c = 0; c < 12; c++) begin
            asi_ss0_valid = 1'b1;
            asi_ss0_data  = b[idx];
            cycle();
            if (last_acc) idx++;
        end
        check("s3_accepted", 24'(idx), 24'd8);
        check("s3_ready_low", 24'(asi_ss0_ready), 24'd0);
        check("s3_level_full", 24'(o_level), 24'd8);
        i_enable = 1'b1;
        for (int c = 0; c < 125; c++) begin
            asi_ss0_valid = (idx < 12);
            asi_ss0_data  = b[idx < 12 ? idx : 11];
            cycle();
            if (last_acc) idx++;
        end
        asi_ss0_valid = 1'b0;
        check("s3_all_taken", 24'(idx), 24'd12);
        check("s3_count", 24'(seen.size()), 24'd12);
        for (int i = 0; i < 12; i++) check("s3_order", seen[i], b[i][23:0]);
        check("s5_signed", seen[4], 24'hFFFFFF);
        check("s3_no_underrun", 24'(ucount), 24'd0);

        // Random traffic at three input rates with sporadic enable toggles.
        for (int seg = 0; seg < 3; seg++) begin
            for (int c = 0; c < 500; c++) begin
                case (seg)
                    0:       asi_ss0_valid = ($urandom_range(0, 1) == 0);
                    1:       asi_ss0_valid = ($urandom_range(0, 11) == 0);
                    default: asi_ss0_valid = ($urandom_range(0, 3) == 0);
                endcase
                asi_ss0_data = $urandom;
                if ($urandom_range(0, 299) == 0) i_enable = ~i_enable;
                cycle();
            end
        end
        asi_ss0_valid = 1'b0;

        // Reset mid-run with level 5 and a push in flight.
        n_rst = 1'b0;
        model_reset();
        cycle();
        #2 n_rst = 1'b1;
        i_enable = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            asi_ss0_valid = 1'b1;
            asi_ss0_data  = 32'h100 + 32'(i);
            cycle();
        end
        asi_ss0_valid = 1'b0;
        cycle();
        check("s6_level5", 24'(o_level), 24'd5);
        check("s6_in_run", 24'(mode), 24'd2);
        asi_ss0_valid = 1'b1;
        asi_ss0_data  = 32'h00777777;
        #2 n_rst = 1'b0;
        model_reset();
        #1;
        check("s6_async_ready", 24'(asi_ss0_ready), 24'd0);
        check("s6_async_level", 24'(o_level), 24'd0);
        check("s6_async_sample", o_sample, 24'd0);
        check("s6_async_strobe", 24'(o_sample_strobe), 24'd0);
        repeat (3) cycle();
        asi_ss0_valid = 1'b0;
        #2 n_rst = 1'b1;
        seen.delete();
        for (int i = 1; i <= 4; i++) begin
            asi_ss0_valid = 1'b1;
            asi_ss0_data  = 32'h200 + 32'(i);
            cycle();
        end
        asi_ss0_valid = 1'b0;
        repeat (45) cycle();
        check("s6_count", 24'(seen.size()), 24'd4);
        for (int i = 0; i < 4; i++)
            check("s6_fresh", seen[i], 24'h200 + 24'(i + 1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
